// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the text-mode pixel pipeline: IO command codes, reset
// colors, cursor geometry, the register-file record and a color helper.
// -----------------------------------------------------------------------------
package gpu_pkg;

    // IO command codes carried in io_data_i[15:8].
    localparam logic [7:0] CMD_BG      = 8'h00;
    localparam logic [7:0] CMD_FG      = 8'h02;
    localparam logic [7:0] CMD_MODE    = 8'h04;
    localparam logic [7:0] CMD_CUR_COL = 8'h08;
    localparam logic [7:0] CMD_CUR_ROW = 8'h09;
    localparam logic [7:0] CMD_CUR_EN  = 8'h0A;

    localparam logic [7:0] RESET_BG = 8'h00;
    localparam logic [7:0] RESET_FG = 8'hFF;

    // Cursor is drawn on the bottom CURSOR_HEIGHT glyph rows of its cell.
    localparam int CURSOR_HEIGHT = 2;

    typedef enum logic {
        MODE_GLOBAL = 1'b0,  // fg/bg come from the color registers
        MODE_CELL   = 1'b1   // fg/bg come from the cell attribute byte
    } color_mode_e;

    // Full programmable register set (shadow and active copies).
    typedef struct packed {
        logic [7:0]  bg;
        logic [7:0]  fg;
        color_mode_e mode;
        logic [7:0]  cur_col;
        logic [7:0]  cur_row;
        logic        cur_en;
    } gpu_regs_t;

    // Color context snapshotted with each pixel as it enters the pipeline.
    typedef struct packed {
        logic [7:0]  bg;
        logic [7:0]  fg;
        color_mode_e mode;
    } color_ctx_t;

    localparam gpu_regs_t REGS_RESET = '{
        bg:      RESET_BG,
        fg:      RESET_FG,
        mode:    MODE_GLOBAL,
        cur_col: 8'd0,
        cur_row: 8'd0,
        cur_en:  1'b0
    };

    // Expand a 4-bit attribute color into an 8-bit palette value.
    function automatic logic [7:0] dup_nibble(input logic [3:0] n);
        return {n, n};
    endfunction

endpackage

// File: rtl/gpu_regfile.sv
// -----------------------------------------------------------------------------
// gpu_regfile
// IO-programmable register file with shadow/active copies plus the cursor
// blink timer. Writes land in the shadow set immediately; the active set is
// refreshed from the shadow set on each frame_start_i so that the picture never
// changes mid-frame.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   io_we_i         : register write strobe
//   io_data_i[15:0] : {cmd[7:0], value[7:0]}
//   frame_start_i   : one-cycle pulse at frame start
//   active_o        : active register set used by the pixel pipeline
//   blink_on_o      : cursor blink phase (1 = cursor visible)
// -----------------------------------------------------------------------------
module gpu_regfile
    import gpu_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_we_i,
    input  logic [15:0] io_data_i,
    input  logic        frame_start_i,
    output gpu_regs_t   active_o,
    output logic        blink_on_o
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    gpu_regs_t   shadow_q, shadow_d;
    gpu_regs_t   active_q;
    logic [BW-1:0] blink_cnt_q;
    logic        blink_on_q;

    logic [7:0] cmd;
    logic [7:0] value;

    assign cmd   = io_data_i[15:8];
    assign value = io_data_i[7:0];

    // Next shadow state including this cycle's write. Feeding shadow_d (not
    // shadow_q) into the active copy makes a write coinciding with
    // frame_start_i take effect on that same edge.
    always_comb begin
        // NOTE: assigning a full default first keeps every path driven, so no
        // latch is inferred when a command code is not matched.
        shadow_d = shadow_q;
        if (io_we_i) begin
            case (cmd)
                CMD_BG:      shadow_d.bg      = value;
                CMD_FG:      shadow_d.fg      = value;
                CMD_MODE:    shadow_d.mode    = color_mode_e'(value[0]);
                CMD_CUR_COL: shadow_d.cur_col = value;
                CMD_CUR_ROW: shadow_d.cur_row = value;
                CMD_CUR_EN:  shadow_d.cur_en  = value[0];
                default:     ;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= REGS_RESET;
            active_q    <= REGS_RESET;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            if (frame_start_i) begin
                active_q <= shadow_d;
                if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q <= '0;
                    blink_on_q  <= ~blink_on_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    assign active_o   = active_q;
    assign blink_on_o = blink_on_q;

endmodule

// File: rtl/text_pixel_pipeline.sv
// -----------------------------------------------------------------------------
// text_pixel_pipeline
// Three-stage, non-stalling text-mode renderer: one pixel in, one color out per
// cycle, three cycles later.
//   S0: split coordinates into cell/offset, register the VRAM address and the
//       cursor hit (evaluated against the active registers at entry).
//   S1: VRAM word arrives; register the font ROM address.
//   S2: font row arrives; pick the glyph bit and register the color.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   pix_valid_i         : pixel request valid
//   pix_x_i, pix_y_i    : pixel coordinates
//   frame_start_i       : one-cycle pulse at frame start
//   vram_addr_o         : cell address row*COLS+col (0 when out of range)
//   vram_data_i         : {attr, char}, valid one cycle after vram_addr_o
//   font_addr_o         : char*CHAR_HEIGHT + glyph row
//   font_data_i         : glyph row, MSB leftmost, valid one cycle after address
//   io_we_i, io_data_i  : register write {cmd, value}
//   pix_valid_o         : pixel valid, 3 cycles after pix_valid_i
//   pix_color_o         : pixel color, held while pix_valid_o is low
// -----------------------------------------------------------------------------
module text_pixel_pipeline
    import gpu_pkg::*;
#(
    parameter int CHAR_WIDTH   = 8,
    parameter int CHAR_HEIGHT  = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid_i,
    input  logic [9:0]  pix_x_i,
    input  logic [9:0]  pix_y_i,
    input  logic        frame_start_i,
    output logic [11:0] vram_addr_o,
    input  logic [15:0] vram_data_i,
    output logic [11:0] font_addr_o,
    input  logic [7:0]  font_data_i,
    input  logic        io_we_i,
    input  logic [15:0] io_data_i,
    output logic        pix_valid_o,
    output logic [7:0]  pix_color_o
);

    localparam int XW = $clog2(CHAR_WIDTH);
    localparam int YW = $clog2(CHAR_HEIGHT);
    localparam int CW = 10 - XW;
    localparam int RW = 10 - YW;

    gpu_regs_t regs;
    logic      blink_on;

    gpu_regfile #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_regfile (
        .clk           (clk),
        .rst           (rst),
        .io_we_i       (io_we_i),
        .io_data_i     (io_data_i),
        .frame_start_i (frame_start_i),
        .active_o      (regs),
        .blink_on_o    (blink_on)
    );

    // ---------------- S0: coordinate split and VRAM address ----------------
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [XW-1:0] x_off;
    logic [YW-1:0] y_off;
    logic          in_range;
    logic          cursor_hit;
    logic [11:0]   vram_addr_d;

    assign col   = pix_x_i[9:XW];
    assign row   = pix_y_i[9:YW];
    assign x_off = pix_x_i[XW-1:0];
    assign y_off = pix_y_i[YW-1:0];

    assign in_range    = (int'(col) < COLS) && (int'(row) < ROWS);
    assign vram_addr_d = in_range ? 12'(int'(row) * COLS + int'(col)) : 12'd0;

    // Evaluated at entry so a later active-register update cannot affect
    // pixels already in flight.
    assign cursor_hit = regs.cur_en && blink_on
                     && (8'(col) == regs.cur_col) && (8'(row) == regs.cur_row)
                     && (int'(y_off) >= CHAR_HEIGHT - CURSOR_HEIGHT)
                     && in_range;

    logic          s0_valid_q;
    logic [11:0]   vram_addr_q;
    logic [XW-1:0] s0_x_off_q;
    logic [YW-1:0] s0_y_off_q;
    logic          s0_in_range_q;
    logic          s0_cursor_q;
    color_ctx_t    s0_ctx_q;

    // ---------------- S1: font address ----------------
    logic [11:0]   font_addr_d;
    assign font_addr_d = 12'(int'(vram_data_i[7:0]) * CHAR_HEIGHT + int'(s0_y_off_q));

    logic          s1_valid_q;
    logic [11:0]   font_addr_q;
    logic [XW-1:0] s1_x_off_q;
    logic          s1_in_range_q;
    logic          s1_cursor_q;
    color_ctx_t    s1_ctx_q;
    logic [7:0]    s1_attr_q;

    // ---------------- S2: color selection ----------------
    logic [XW-1:0] bit_idx;
    logic          lit;
    logic [7:0]    fg_sel;
    logic [7:0]    bg_sel;
    logic [7:0]    color_d;

    assign bit_idx = XW'(CHAR_WIDTH - 1) - s1_x_off_q;
    assign lit     = font_data_i[bit_idx];
    assign fg_sel  = (s1_ctx_q.mode == MODE_CELL) ? dup_nibble(s1_attr_q[3:0]) : s1_ctx_q.fg;
    assign bg_sel  = (s1_ctx_q.mode == MODE_CELL) ? dup_nibble(s1_attr_q[7:4]) : s1_ctx_q.bg;

    // Out-of-range pixels always show the active global background.
    assign color_d = !s1_in_range_q            ? s1_ctx_q.bg :
                     (s1_cursor_q || lit)      ? fg_sel      : bg_sel;

    logic          pix_valid_q;
    logic [7:0]    pix_color_q;

    // Control path and visible outputs: reset so in-flight pixels are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            vram_addr_q <= '0;
            s1_valid_q  <= 1'b0;
            font_addr_q <= '0;
            pix_valid_q <= 1'b0;
            pix_color_q <= '0;
        end else begin
            s0_valid_q  <= pix_valid_i;
            vram_addr_q <= vram_addr_d;
            s1_valid_q  <= s0_valid_q;
            font_addr_q <= font_addr_d;
            pix_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                pix_color_q <= color_d;
            end
        end
    end

    // NOTE: the per-pixel side data needs no reset; it is only ever consumed
    // alongside a valid bit, and the valid bits are reset above.
    always_ff @(posedge clk) begin
        s0_x_off_q    <= x_off;
        s0_y_off_q    <= y_off;
        s0_in_range_q <= in_range;
        s0_cursor_q   <= cursor_hit;
        s0_ctx_q      <= '{bg: regs.bg, fg: regs.fg, mode: regs.mode};

        s1_x_off_q    <= s0_x_off_q;
        s1_in_range_q <= s0_in_range_q;
        s1_cursor_q   <= s0_cursor_q;
        s1_ctx_q      <= s0_ctx_q;
        s1_attr_q     <= vram_data_i[15:8];
    end

    assign vram_addr_o = vram_addr_q;
    assign font_addr_o = font_addr_q;
    assign pix_valid_o = pix_valid_q;
    assign pix_color_o = pix_color_q;

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// -----------------------------------------------------------------------------
// tb_text_pixel_pipeline
// Directed bench for text_pixel_pipeline. VRAM and font ROM are modelled as
// arrays read combinationally from the registered addresses, which makes the
// data valid one cycle after each address. Inputs change on the falling edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_text_pixel_pipeline;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic [9:0]  pix_x_i = '0;
    logic [9:0]  pix_y_i = '0;
    logic        frame_start_i = 1'b0;
    logic [11:0] vram_addr_o;
    logic [15:0] vram_data_i;
    logic [11:0] font_addr_o;
    logic [7:0]  font_data_i;
    logic        io_we_i = 1'b0;
    logic [15:0] io_data_i = '0;
    logic        pix_valid_o;
    logic [7:0]  pix_color_o;

    logic [15:0] vram_mem [4096];
    logic [7:0]  font_mem [4096];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign vram_data_i = vram_mem[vram_addr_o];
    assign font_data_i = font_mem[font_addr_o];

    text_pixel_pipeline dut (
        .clk           (clk),
        .rst           (rst),
        .pix_valid_i   (pix_valid_i),
        .pix_x_i       (pix_x_i),
        .pix_y_i       (pix_y_i),
        .frame_start_i (frame_start_i),
        .vram_addr_o   (vram_addr_o),
        .vram_data_i   (vram_data_i),
        .font_addr_o   (font_addr_o),
        .font_data_i   (font_data_i),
        .io_we_i       (io_we_i),
        .io_data_i     (io_data_i),
        .pix_valid_o   (pix_valid_o),
        .pix_color_o   (pix_color_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] cmd, input logic [7:0] value, input logic fs);
        @(negedge clk);
        io_we_i       = 1'b1;
        io_data_i     = {cmd, value};
        frame_start_i = fs;
        @(negedge clk);
        io_we_i       = 1'b0;
        frame_start_i = 1'b0;
    endtask

    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start_i = 1'b1;
            @(negedge clk);
            frame_start_i = 1'b0;
        end
    endtask

    // One isolated pixel: checks VRAM address after S0, font address and
    // no-early-valid after S1, then valid and color exactly 3 edges in.
    task automatic run_pixel(input string tag, input int x, input int y,
                             input logic [11:0] exp_vaddr, input logic [11:0] exp_faddr,
                             input logic [7:0] exp_color);
        @(negedge clk);
        pix_valid_i = 1'b1;
        pix_x_i     = 10'(x);
        pix_y_i     = 10'(y);
        @(negedge clk);
        pix_valid_i = 1'b0;
        check({tag, "/vaddr"}, 32'(vram_addr_o), 32'(exp_vaddr));
        @(negedge clk);
        check({tag, "/faddr"}, 32'(font_addr_o), 32'(exp_faddr));
        check({tag, "/early"}, 32'(pix_valid_o), 32'd0);
        @(negedge clk);
        check({tag, "/valid"}, 32'(pix_valid_o), 32'd1);
        check({tag, "/color"}, 32'(pix_color_o), 32'(exp_color));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            vram_mem[i] = 16'h0000;
            font_mem[i] = 8'h00;
        end
        vram_mem[0]     = 16'h0041;  // 'A', attr 0
        font_mem[12'h410] = 8'h80;   // 'A' row 0: leftmost pixel lit
        vram_mem[3]     = 16'h3A42;  // attr 0x3A, char 0x42
        vram_mem[82]    = 16'h0020;  // cell (2,1): space

        // Reset state.
        do_reset();
        check("rst/valid", 32'(pix_valid_o), 32'd0);
        check("rst/color", 32'(pix_color_o), 32'd0);
        check("rst/vaddr", 32'(vram_addr_o), 32'd0);
        check("rst/faddr", 32'(font_addr_o), 32'd0);

        // Lit pixel with global fg, then an out-of-range pixel (col 80).
        run_pixel("lit00", 0, 0, 12'd0, 12'h410, 8'hFF);
        run_pixel("oor647", 647, 0, 12'd0, 12'h410, 8'h00);

        // Background write stays in shadow until frame_start.
        io_write(8'h00, 8'h1C, 1'b0);
        run_pixel("bg_shadow", 1, 0, 12'd0, 12'h410, 8'h00);
        frame_pulses(1);
        run_pixel("bg_active", 1, 0, 12'd0, 12'h410, 8'h1C);

        // Per-cell colors: attr 0x3A -> bg 0x33, fg 0xAA.
        io_write(8'h04, 8'h01, 1'b0);
        frame_pulses(1);
        run_pixel("cell_unlit", 24, 0, 12'd3, 12'h420, 8'h33);
        font_mem[12'h420] = 8'hFF;
        run_pixel("cell_lit", 24, 0, 12'd3, 12'h420, 8'hAA);

        // Cursor at (2,1); enable lands on the same edge as a frame_start.
        do_reset();
        io_write(8'h08, 8'h02, 1'b0);
        io_write(8'h09, 8'h01, 1'b0);
        io_write(8'h0A, 8'h01, 1'b1);
        run_pixel("cur_on", 16, 30, 12'd82, 12'h20E, 8'hFF);
        run_pixel("cur_row13", 16, 29, 12'd82, 12'h20D, 8'h00);
        run_pixel("cur_othercell", 24, 30, 12'd83, 12'h00E, 8'h00);
        frame_pulses(29);
        run_pixel("cur_blink_off", 16, 30, 12'd82, 12'h20E, 8'h00);
        frame_pulses(30);
        run_pixel("cur_blink_on", 16, 30, 12'd82, 12'h20E, 8'hFF);

        // Write and frame_start in the same cycle; then an ignored command.
        io_write(8'h00, 8'h55, 1'b1);
        run_pixel("we_fs_same", 647, 0, 12'd0, 12'h410, 8'h55);
        io_write(8'h01, 8'h99, 1'b1);
        run_pixel("bad_cmd", 647, 0, 12'd0, 12'h410, 8'h55);
        repeat (2) @(negedge clk);
        check("hold/valid", 32'(pix_valid_o), 32'd0);
        check("hold/color", 32'(pix_color_o), 32'h55);

        // Reset in the middle of a pixel stream drops the in-flight pixels.
        @(negedge clk);
        pix_valid_i = 1'b1;
        pix_x_i     = 10'd16;
        pix_y_i     = 10'd29;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst/v0", 32'(pix_valid_o), 32'd0);
        check("midrst/color", 32'(pix_color_o), 32'd0);
        @(negedge clk);
        check("midrst/v1", 32'(pix_valid_o), 32'd0);
        @(negedge clk);
        check("midrst/v2", 32'(pix_valid_o), 32'd0);
        @(negedge clk);
        pix_valid_i = 1'b0;
        check("midrst/v3", 32'(pix_valid_o), 32'd1);
        check("midrst/c3", 32'(pix_color_o), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
